// File: rtl/spi_tx_pkg.sv
// Shared types and constants for the SPI target transmit path.
package spi_tx_pkg;

  // Top-level transmitter states.
  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

  // Fewest synchronizer flops that still give a usable metastability margin.
  localparam int unsigned MinSyncStages = 2;

  // Word driven onto MISO when the host clocks a word and upstream has none.
  localparam logic [7:0] DefaultIdleValue = 8'hFF;

endpackage

// File: rtl/spi_sync_ff.sv
// N-stage flop synchronizer with a selectable reset value.
module spi_sync_ff
  import spi_tx_pkg::*;
#(
  parameter int unsigned Stages     = MinSyncStages,
  parameter bit          ResetValue = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_d;
  logic [Stages-1:0] sync_q;

  // Shift the asynchronous input one stage deeper each clock.
  always_comb begin
    sync_d = {sync_q[Stages-2:0], d_i};
  end

  // Synchronizer chain; resets to the idle level of the pin it guards.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {Stages{ResetValue}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/spi_target_tx.sv
// SPI mode-0 target transmitter: oversamples SCK/CSB in the system clock
// domain, pulls words over a valid/ready handshake and shifts them out on MISO.
module spi_target_tx
  import spi_tx_pkg::*;
#(
  parameter int unsigned      Width      = 8,
  parameter bit               MsbFirst   = 1'b1,
  parameter int unsigned      SyncStages = 2,
  parameter logic [Width-1:0] IdleValue  = Width'(DefaultIdleValue),
  parameter int unsigned      CntWidth   = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                spi_sck_i,
  input  logic                spi_csb_i,
  output logic                spi_miso_o,
  output logic                spi_miso_en_o,
  input  logic                tx_valid_i,
  input  logic [Width-1:0]    tx_data_i,
  output logic                tx_ready_o,
  output logic                word_done_o,
  output logic                underrun_o,
  output logic                abort_o,
  output logic [CntWidth-1:0] tx_count_o
);

  localparam int unsigned SyncDepth = (SyncStages < MinSyncStages) ? MinSyncStages : SyncStages;
  localparam int unsigned BitCntW   = $clog2(Width);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(Width - 1);

  logic sck_s;
  logic csb_s;

  state_e              state_d, state_q;
  logic                sck_d1_d, sck_d1_q;
  logic                csb_d1_d, csb_d1_q;
  logic [Width-1:0]    shift_d, shift_q;
  logic [BitCntW-1:0]  bit_cnt_d, bit_cnt_q;
  logic                reload_pend_d, reload_pend_q;
  logic [CntWidth-1:0] count_d, count_q;
  logic                en_d, en_q;
  logic [SyncDepth-1:0] flush_d, flush_q;
  logic                armed_d, armed_q;

  logic sck_rise;
  logic sck_fall;
  logic csb_rise;
  logic csb_fall;
  logic load;
  logic word_done;
  logic abort;

  spi_sync_ff #(
    .Stages     (SyncDepth),
    .ResetValue (1'b0)
  ) u_sync_sck (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (spi_sck_i),
    .q_o    (sck_s)
  );

  spi_sync_ff #(
    .Stages     (SyncDepth),
    .ResetValue (1'b1)
  ) u_sync_csb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (spi_csb_i),
    .q_o    (csb_s)
  );

  // Edge strobes from the synchronized pins and their one-cycle-old copies.
  // The synchronizer resets to "deselected", so a CSB already low at reset
  // release would look like a fall; armed only opens once CSB has been seen
  // high after the chain has flushed real pin samples through.
  always_comb begin
    sck_rise = sck_s & ~sck_d1_q;
    sck_fall = ~sck_s & sck_d1_q;
    csb_rise = csb_s & ~csb_d1_q;
    csb_fall = ~csb_s & csb_d1_q & armed_q;
    sck_d1_d = sck_s;
    csb_d1_d = csb_s;
    flush_d  = {flush_q[SyncDepth-2:0], 1'b1};
    armed_d  = armed_q | (flush_q[SyncDepth-1] & csb_s);
  end

  // Transaction FSM, bit counter, word reload and shift register update.
  // CSB rise takes priority over any SCK edge seen in the same cycle.
  always_comb begin
    state_d       = state_q;
    en_d          = en_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    reload_pend_d = reload_pend_q;
    count_d       = count_q;
    load          = 1'b0;
    word_done     = 1'b0;
    abort         = 1'b0;

    if (state_q == StIdle) begin
      if (csb_fall) begin
        load          = 1'b1;
        state_d       = StShift;
        en_d          = 1'b1;
        count_d       = '0;
        reload_pend_d = 1'b0;
      end
    end else begin
      if (csb_rise) begin
        state_d = StIdle;
        en_d    = 1'b0;
        abort   = (bit_cnt_q != '0);
      end else if (sck_rise) begin
        if (bit_cnt_q == LastBit) begin
          bit_cnt_d     = '0;
          word_done     = 1'b1;
          reload_pend_d = 1'b1;
          if (count_q != '1) begin
            count_d = count_q + CntWidth'(1);
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
        end
      end else if (sck_fall) begin
        if (reload_pend_q) begin
          load          = 1'b1;
          reload_pend_d = 1'b0;
        end else if (MsbFirst) begin
          shift_d = {shift_q[Width-2:0], 1'b0};
        end else begin
          shift_d = {1'b0, shift_q[Width-1:1]};
        end
      end
    end

    if (load) begin
      shift_d   = tx_valid_i ? tx_data_i : IdleValue;
      bit_cnt_d = '0;
    end
  end

  // State registers; everything returns to the deselected idle picture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      sck_d1_q      <= 1'b0;
      csb_d1_q      <= 1'b1;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      reload_pend_q <= 1'b0;
      count_q       <= '0;
      en_q          <= 1'b0;
      flush_q       <= '0;
      armed_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      sck_d1_q      <= sck_d1_d;
      csb_d1_q      <= csb_d1_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      reload_pend_q <= reload_pend_d;
      count_q       <= count_d;
      en_q          <= en_d;
      flush_q       <= flush_d;
      armed_q       <= armed_d;
    end
  end

  assign spi_miso_o    = MsbFirst ? shift_q[Width-1] : shift_q[0];
  assign spi_miso_en_o = en_q;
  assign tx_ready_o    = load & tx_valid_i;
  assign underrun_o    = load & ~tx_valid_i;
  assign word_done_o   = word_done;
  assign abort_o       = abort;
  assign tx_count_o    = count_q;

endmodule

// File: doc/spi_target_tx.md
Name: spi_target_tx

Overview:
- Transmit (MISO) side of the SPI target peripheral, running in the system clock domain.
- Oversamples the host's SCK and CSB, accepts bytes from the register/FIFO side over a valid/ready handshake, and shifts them out in SPI mode 0 (CPOL=0, CPHA=0).
- Sits between the TX data path and the SPI pads; the existing RX capture logic is its counterpart.

Parameters:
- Width, 8, bits per SPI word.
- MsbFirst, 1, 1 sends bit Width-1 first; 0 sends bit 0 first.
- SyncStages, 2, synchronizer depth for spi_sck_i and spi_csb_i (minimum 2).
- IdleValue, 8'hFF, word sent on underrun (Width bits).
- CntWidth, 16, width of the completed-word counter.

Ports:
- clk_i  input  1  system clock; f_clk must be at least 4*f_sck + margin.
- rst_ni  input  1  asynchronous active-low reset.
- spi_sck_i  input  1  host SCK, asynchronous.
- spi_csb_i  input  1  host chip select, active-low, asynchronous.
- spi_miso_o  output  1  serial data out.
- spi_miso_en_o  output  1  pad output enable; 1 while selected.
- tx_valid_i  input  1  tx_data_i holds a word.
- tx_data_i  input  Width  word to send.
- tx_ready_o  output  1  one-cycle pulse; word consumed when tx_valid_i & tx_ready_o.
- word_done_o  output  1  pulse: last bit of a word sampled by the host.
- underrun_o  output  1  pulse: load needed, no valid word, IdleValue sent.
- abort_o  output  1  pulse: CSB deasserted mid-word.
- tx_count_o  output  CntWidth  words completed in the current transaction.

Behaviour:
- Reset: asynchronous assert, synchronous release. All flops including synchronizers reset. Synchronizers reset to sck=0 and csb=1. Outputs at reset: spi_miso_o=0, spi_miso_en_o=0, tx_ready_o=0, word_done_o=0, underrun_o=0, abort_o=0, tx_count_o=0. State is IDLE.
- Edge detection: sck_s and csb_s are the synchronized signals. Each has a one-cycle-delayed copy, from which rise and fall strobes are derived. Edge-to-action latency is SyncStages+1 clk.
- States:
  - IDLE: spi_miso_en_o=0. A csb fall causes LOAD and moves to SHIFT.
  - SHIFT: spi_miso_en_o=1.
  - Any csb rise returns to IDLE.
- LOAD (single cycle):
  - If tx_valid_i=1: tx_ready_o=1 and shift_reg<=tx_data_i.
  - If tx_valid_i=0: shift_reg<=IdleValue and underrun_o=1.
  - In both cases bit_cnt<=0.
- Output bit: spi_miso_o = shift_reg[Width-1] when MsbFirst=1, otherwise shift_reg[0]. It is registered; no combinational path from the pins.
- sck rise in SHIFT:
  - If bit_cnt==Width-1: bit_cnt<=0, word_done_o=1, tx_count_o increments (saturating at all-ones), reload_pend<=1.
  - Otherwise bit_cnt increments.
- sck fall in SHIFT:
  - If reload_pend=1: LOAD and clear reload_pend.
  - Otherwise shift by one toward the output bit, filling with 0.
- csb fall: tx_count_o<=0 and reload_pend<=0.
- csb rise in SHIFT:
  - abort_o=1 if bit_cnt!=0. The partially sent word is discarded, not re-sent.
  - Go to IDLE; spi_miso_en_o<=0 on the same edge.
  - The last spi_miso_o value is held.
  - tx_count_o holds its value until the next csb fall.
- Simultaneous edges:
  - csb rise wins over any same-cycle sck edge; no shift, load or word_done occurs.
  - An sck edge while csb_s=1 is ignored.
- A csb fall and sck rise in the same sampled cycle is a host protocol violation. The design performs LOAD and ignores that sck edge.
- tx_ready_o is asserted only in a LOAD cycle and never in IDLE. Upstream must hold tx_data_i stable while tx_valid_i=1.
- Reset mid-transaction returns to IDLE immediately; the in-flight word is lost.

Decomposition:
- Package spi_tx_pkg holds:
  - the state enum (StIdle, StShift);
  - the minimum SyncStages constant;
  - the default IdleValue constant.
- Sub-module spi_sync_ff: parameterized N-stage synchronizer with reset value parameter, instantiated twice (sck reset 0, csb reset 1).
- Edge detect, FSM, shift register and counter stay in the top module.

Test Plan:
- Single word, MsbFirst=1, tx_data_i=8'hA5 valid before csb fall, f_sck=f_clk/8 -> MISO bits 1,0,1,0,0,1,0,1; tx_ready_o pulses once; word_done_o once; tx_count_o=1.
- Back-to-back words 8'h3C then 8'hC3 with valid held, 16 SCKs -> 0011110011000011 on MISO; two tx_ready_o pulses; tx_count_o=2; no underrun_o.
- Underrun: tx_valid_i=0 at csb fall, IdleValue=8'hFF -> MISO all ones for 8 bits; underrun_o=1 once; tx_ready_o never asserted.
- Abort: csb rise after 3 SCK rises with word 8'hF0 -> abort_o=1; spi_miso_en_o=0 within SyncStages+1 clk; next transaction starts with a new handshake and tx_count_o=0.
- MsbFirst=0, tx_data_i=8'h01 -> first bit 1, then seven 0s.
- Async reset asserted mid-word (bit 4) -> all outputs at reset values immediately; after release with csb still low, no activity until a fresh csb fall.
